passcode_entry: RTL and testbench

PASSCODE_ENTRY -- requirements
Module: passcode_entry

---
 rtl/lock_pkg.sv | 34 +++
 rtl/button_sync.sv | 38 +++
 rtl/passcode_entry.sv | 126 ++++++++++++
 tb/tb_passcode_entry.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the passcode lock: state codes, digit count and
// the digit-priority helper used when several keys fire together.
package lock_pkg;

    localparam int DIGIT_COUNT = 8;
    localparam int SEQ_W       = 4 * DIGIT_COUNT;

    typedef enum logic [3:0] {
        LS0   = 4'd0,
        LS1   = 4'd1,
        LS2   = 4'd2,
        LS3   = 4'd3,
        LS4   = 4'd4,
        LS5   = 4'd5,
        LS6   = 4'd6,
        LS7   = 4'd7,
        OPEN  = 4'd8,
        ALARM = 4'd9,
        INIT  = 4'd10
    } lock_state_t;

    // Highest-indexed active digit wins when several pulses coincide
    function automatic logic [3:0] highest_digit(input logic [15:0] pulses);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pulses[i]) begin
                d = 4'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/button_sync.sv
// Button conditioner: two-flop synchronizer followed by a rising-edge
// detector. A button must be seen low after reset before it can produce a
// press, so a key held through reset release stays silent.
module button_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] armed;
    logic [1:0]       live;

    // Synchronizer, edge history and per-button arming after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= '0;
            sync  <= '0;
            prev  <= '0;
            armed <= '0;
            live  <= '0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            prev  <= sync;
            live  <= {live[0], 1'b1};
            armed <= armed | ({WIDTH{live[1]}} & ~sync);
        end
    end

    assign pulse = sync & ~prev & armed;

endmodule

// File: rtl/passcode_entry.sv
// Passcode lock controller: records an 8-digit password in INIT, then
// compares each 8-digit entry against it, opening or raising an alarm.
// Optional feature macro: ALARM_TIMEOUT_EN (auto-relock after ALARM_CYCLES).
module passcode_entry
    import lock_pkg::*;
#(
    parameter int ALARM_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key,
    input  logic        set,
    output logic [3:0]  state,
    output logic [31:0] seq
);

    logic [16:0]      pulses;
    logic [15:0]      key_pulse;
    logic             set_pulse;
    logic             digit_press;
    logic [3:0]       digit;
    logic [SEQ_W-1:0] shifted;

    lock_state_t      state_q, state_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] pw_q, pw_d;

    button_sync #(.WIDTH(17)) u_button_sync (
        .clk   (clk),
        .rst   (rst),
        .btn   ({set, key}),
        .pulse (pulses)
    );

    assign key_pulse   = pulses[15:0];
    assign set_pulse   = pulses[16];
    assign digit_press = |key_pulse;
    assign digit       = highest_digit(key_pulse);
    assign shifted     = {seq_q[SEQ_W-5:0], digit};

`ifdef ALARM_TIMEOUT_EN
    localparam int CNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    logic [CNT_W-1:0] alarm_cnt_q, alarm_cnt_d;
    logic             alarm_done;

    assign alarm_done = (alarm_cnt_q == CNT_W'(ALARM_CYCLES - 1));

    // Alarm dwell counter, only running while in ALARM
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_cnt_q <= '0;
        end else begin
            alarm_cnt_q <= alarm_cnt_d;
        end
    end
`endif

    // Lock state, entered digits and stored password
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            seq_q   <= '0;
            pw_q    <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            pw_q    <= pw_d;
        end
    end

    // Next-state decisions driven by the one-cycle press pulses
    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        pw_d    = pw_q;
`ifdef ALARM_TIMEOUT_EN
        alarm_cnt_d = '0;
`endif
        case (state_q)
            INIT: begin
                if (set_pulse) begin
                    pw_d    = seq_q;
                    seq_d   = '0;
                    state_d = LS0;
                end else if (digit_press) begin
                    seq_d = shifted;
                end
            end
            LS0, LS1, LS2, LS3, LS4, LS5, LS6: begin
                if (digit_press) begin
                    seq_d   = shifted;
                    state_d = lock_state_t'(state_q + 4'd1);
                end
            end
            LS7: begin
                if (digit_press) begin
                    seq_d   = shifted;
                    state_d = (shifted == pw_q) ? OPEN : ALARM;
                end
            end
            OPEN: begin
                if (set_pulse) begin
                    seq_d   = '0;
                    state_d = LS0;
                end
            end
            ALARM: begin
`ifdef ALARM_TIMEOUT_EN
                if (alarm_done) begin
                    seq_d   = '0;
                    state_d = LS0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign state = state_q;
    assign seq   = seq_q;

endmodule

// File: tb/tb_passcode_entry.sv
// Testbench for passcode_entry: directed scenarios followed by random
// presses, all compared against a digit-queue model of the lock.
module tb_passcode_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key = 16'h0000;
    logic        set = 1'b0;
    logic [3:0]  state;
    logic [31:0] seq;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int upd_cyc  = 0;

    int         m_state;
    logic [3:0] m_digits[$];
    logic [31:0] m_pw;

    passcode_entry #(.ALARM_CYCLES(20)) dut (
        .clk   (clk),
        .rst   (rst),
        .key   (key),
        .set   (set),
        .state (state),
        .seq   (seq)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time the alarm dwell
    always @(posedge clk) cyc <= cyc + 1;

    // Guard against a hung simulation
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] packSeq();
        logic [31:0] r;
        r = 32'h0;
        foreach (m_digits[i]) r = {r[27:0], m_digits[i]};
        return r;
    endfunction

    function automatic void modelReset();
        m_state = 10;
        m_digits.delete();
        m_pw = 32'h0;
    endfunction

    function automatic void pushDigit(int d);
        m_digits.push_back(4'(d));
        if (m_digits.size() > 8) void'(m_digits.pop_front());
    endfunction

    function automatic void modelPress(logic [15:0] k, logic s);
        int d;
        d = -1;
        for (int i = 0; i < 16; i++) if (k[i]) d = i;
        if (m_state == 10) begin
            if (s) begin
                m_pw = packSeq();
                m_digits.delete();
                m_state = 0;
            end else if (d >= 0) begin
                pushDigit(d);
            end
        end else if (m_state <= 7) begin
            if (d >= 0) begin
                pushDigit(d);
                if (m_state == 7) m_state = (packSeq() == m_pw) ? 8 : 9;
                else m_state = m_state + 1;
            end
        end else if (m_state == 8) begin
            if (s) begin
                m_digits.delete();
                m_state = 0;
            end
        end
    endfunction

    task automatic checkOutput(string tag, logic [3:0] exp_state, logic [31:0] exp_seq);
        checks++;
        assert (state === exp_state) else begin
            failures++;
            $error("[TB] FAIL %s state actual=%0d expected=%0d", tag, state, exp_state);
        end
        checks++;
        assert (seq === exp_seq) else begin
            failures++;
            $error("[TB] FAIL %s seq actual=%h expected=%h", tag, seq, exp_seq);
        end
    endtask

    task automatic checkModel(string tag);
        checkOutput(tag, 4'(m_state), packSeq());
    endtask

    task automatic doReset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        modelReset();
        checkOutput("reset", 4'd10, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic applyStimulus(logic [15:0] k, logic s, int hold, string tag);
        @(posedge clk); #1 key = k; set = s;
        @(posedge clk);
        @(posedge clk); #1;
        checkModel({tag, "_lat"});
        @(posedge clk); #1;
        modelPress(k, s);
        upd_cyc = cyc;
        checkModel(tag);
        if (hold > 3) begin
            repeat (hold - 3) @(posedge clk);
            #1 checkModel({tag, "_held"});
        end
        key = 16'h0000;
        set = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic pressDigit(int d, string tag);
        applyStimulus(16'(1 << d), 1'b0, 3, tag);
    endtask

    task automatic alarmCheck();
`ifdef ALARM_TIMEOUT_EN
        while (cyc < upd_cyc + 19) begin
            @(posedge clk); #1;
        end
        checkOutput("alarm_dwell", 4'd9, packSeq());
        @(posedge clk); #1;
        m_state = 0;
        m_digits.delete();
        checkOutput("alarm_exit", 4'd0, 32'h0);
`else
        applyStimulus(16'h0002, 1'b0, 3, "alarm_key");
        applyStimulus(16'h0000, 1'b1, 3, "alarm_set");
        repeat (1000) @(posedge clk);
        #1 checkOutput("alarm_1000", 4'd9, packSeq());
        doReset();
`endif
    endtask

    initial begin
        logic [15:0] k;
        logic        s;
        int          r;

        $display("[TB] start");
        modelReset();
        doReset();

        // Program 12345678 then unlock with it
        for (int i = 1; i <= 8; i++) pressDigit(i, "init_digit");
        applyStimulus(16'h0000, 1'b1, 3, "init_set");
        checkOutput("lock_ls0", 4'd0, 32'h0);
        for (int i = 1; i <= 8; i++) pressDigit(i, "entry");
        checkOutput("open_literal", 4'd8, 32'h12345678);
        pressDigit(4, "open_digit");
        applyStimulus(16'h0000, 1'b1, 3, "open_set");

        // Wrong last digit raises the alarm
        for (int i = 1; i <= 7; i++) pressDigit(i, "bad_entry");
        pressDigit(9, "bad_last");
        checkOutput("alarm_literal", 4'd9, 32'h12345679);
        alarmCheck();

        // Simultaneous digits and a long hold
        doReset();
        applyStimulus(16'h0000, 1'b1, 3, "to_ls0");
        applyStimulus(16'h0408, 1'b0, 50, "multi_hold");
        checkOutput("multi_literal", 4'd1, 32'h0000000A);

        // Nine-digit wrap, then set beats a digit in INIT
        doReset();
        for (int i = 1; i <= 9; i++) pressDigit(i, "wrap_digit");
        checkOutput("wrap_literal", 4'd10, 32'h23456789);
        applyStimulus(16'h0001, 1'b1, 3, "set_and_digit");
        checkOutput("set_prio", 4'd0, 32'h0);
        for (int i = 2; i <= 9; i++) pressDigit(i, "wrap_entry");
        checkOutput("wrap_open", 4'd8, 32'h23456789);

        // Reset mid-entry with a key held through reset release
        applyStimulus(16'h0000, 1'b1, 3, "relock");
        for (int i = 1; i <= 3; i++) pressDigit(i, "partial");
        @(posedge clk); #1 key = 16'h0020;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        modelReset();
        checkOutput("mid_reset", 4'd10, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 checkOutput("held_reset", 4'd10, 32'h0);
        key = 16'h0000;
        repeat (4) @(posedge clk);
        pressDigit(4, "after_held");
        checkOutput("after_held_lit", 4'd10, 32'h4);

        // Random presses against the model
        doReset();
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            k = 16'(1 << $urandom_range(0, 15));
            s = 1'b0;
            if (r >= 6 && r < 8) k = k | 16'(1 << $urandom_range(0, 15));
            if (r == 8) begin
                k = 16'h0000;
                s = 1'b1;
            end
            if (r == 9) s = 1'b1;
            applyStimulus(k, s, $urandom_range(3, 6), "rand");
            if (m_state == 9) alarmCheck();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
